// File: rtl/pipe_latch_elastic_pkg.sv
// Shared types for the elastic inter-stage pipeline latch: occupancy states,
// occupancy count type, and the stage payload/control structs that users cast
// to and from the flat DATA_W/CTRL_W vectors carried by the latch.
package pipe_latch_elastic_pkg;

    // Occupancy states of one latch: nothing held, main slot held, main+skid held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } pipe_state_t;

    // Number of valid entries held (0..2).
    typedef logic [1:0] occ_t;

    // IF/ID payload: fetched instruction word and its pc.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] rsvd;
    } ifid_data_t;

    // IF/ID control: nothing writes state yet, only a halt marker travels.
    typedef struct packed {
        logic        halt;
        logic [14:0] rsvd;
    } ifid_ctrl_t;

    // ID/EX payload: register operands and immediate.
    typedef struct packed {
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [31:0] pc;
    } idex_data_t;

    // ID/EX control: the bits that must read as zero on a bubble.
    typedef struct packed {
        logic       reg_wr;
        logic       mem_wr;
        logic       d_ren;
        logic       d_wen;
        logic       halt;
        logic [3:0] alu_op;
        logic [4:0] wsel;
        logic [1:0] rsvd;
    } idex_ctrl_t;

    // Entry count implied by a state.
    function automatic occ_t occ_of_state(input pipe_state_t s);
        case (s)
            FULL:    return 2'd1;
            SKIDF:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_latch_elastic_if.sv
// Valid/ready stream carrying an opaque payload plus a control field.
// The producer side uses the master modport, the consumer side the slave.
interface pipe_latch_elastic_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );
endinterface

// File: rtl/pipe_latch_elastic_slot.sv
// One storage slot: valid bit, payload and control. Clear kills the entry by
// zeroing valid and control but keeps the payload, so a bubble never carries
// live control bits while the data lines stay quiet.
module pipe_latch_elastic_slot #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Slot register; clear wins over load so a kill cannot be overridden.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_latch_elastic.sv
// Elastic pipeline register between two datapath stages. With SKID=1 a second
// slot absorbs the entry that arrives in the cycle the consumer stalls, so
// in_ready is a plain register and out_ready never reaches it combinationally.
// With SKID=0 it is a single slot whose in_ready follows out_ready directly.
module pipe_latch_elastic
    import pipe_latch_elastic_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    pipe_latch_elastic_if.slave   in_if,
    pipe_latch_elastic_if.master  out_if,
    input  logic                  flush,
    output occ_t                  occupancy
);

    pipe_state_t       state_reg;
    pipe_state_t       state_next;
    logic              in_ready_reg;
    occ_t              occupancy_reg;

    logic              in_ready;
    logic              accept;
    logic              drain;

    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;

    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign accept = in_if.valid & in_ready;
    assign drain  = main_valid & out_if.ready;

    // While the skid slot is occupied it is older than anything upstream,
    // so it is always the source for the main slot.
    assign main_d_data = skid_valid ? skid_data : in_if.data;
    assign main_d_ctrl = skid_valid ? skid_ctrl : in_if.ctrl;

    // Next-state and slot load/clear decisions; flush kills everything held and
    // discards the entry offered this cycle.
    always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_load  = 1'b1;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (drain && accept) begin
                        main_load = 1'b1;
                    end else if (drain) begin
                        main_clear = 1'b1;
                        state_next = EMPTY;
                    end else if (accept) begin
                        // Only reachable with a skid slot: single-slot in_ready
                        // is low whenever full and stalled.
                        skid_load  = 1'b1;
                        state_next = SKIDF;
                    end
                end
                SKIDF: begin
                    if (out_if.ready) begin
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                        state_next = FULL;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // State, registered in_ready and occupancy all advance together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            occupancy_reg <= '0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != SKIDF);
            occupancy_reg <= occ_of_state(state_next);
        end
    end

    pipe_latch_elastic_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .CLK    (CLK),
        .nRST   (nRST),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .valid  (main_valid),
        .data   (main_data),
        .ctrl   (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_latch_elastic_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .CLK    (CLK),
                .nRST   (nRST),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_data (in_if.data),
                .d_ctrl (in_if.ctrl),
                .valid  (skid_valid),
                .data   (skid_data),
                .ctrl   (skid_ctrl)
            );
            assign in_ready = in_ready_reg;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
            assign in_ready   = !main_valid || out_if.ready;
        end
    endgenerate

    assign in_if.ready  = in_ready;
    assign out_if.valid = main_valid;
    assign out_if.data  = main_data;
    assign out_if.ctrl  = main_ctrl;
    assign occupancy    = occupancy_reg;

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Bench for pipe_latch_elastic: a skid instance and a single-slot instance share
// the same stimulus; each is compared every cycle against a FIFO-queue model.
module tb_pipe_latch_elastic;
    import pipe_latch_elastic_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          flush = 1'b0;
    logic          iv = 1'b0;
    logic [DW-1:0] id = '0;
    logic [CW-1:0] ic = '0;
    logic          ordy = 1'b0;
    occ_t          occ_a;
    occ_t          occ_b;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: queue of held entries, last visible payload, and for
    // the skid instance the in_ready value registered at the last edge.
    ent_t          qa[$];
    ent_t          qb[$];
    logic          ra = 1'b1;
    logic [DW-1:0] lda = '0;
    logic [DW-1:0] ldb = '0;

    always #5 CLK = ~CLK;

    pipe_latch_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) a_in ();
    pipe_latch_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) a_out ();
    pipe_latch_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) b_in ();
    pipe_latch_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) b_out ();

    assign a_in.valid  = iv;
    assign a_in.data   = id;
    assign a_in.ctrl   = ic;
    assign a_out.ready = ordy;
    assign b_in.valid  = iv;
    assign b_in.data   = id;
    assign b_in.ctrl   = ic;
    assign b_out.ready = ordy;

    pipe_latch_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_if     (a_in),
        .out_if    (a_out),
        .flush     (flush),
        .occupancy (occ_a)
    );

    pipe_latch_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_if     (b_in),
        .out_if    (b_out),
        .flush     (flush),
        .occupancy (occ_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        logic [CW-1:0] ca;
        logic [CW-1:0] cb;
        ca = '0;
        cb = '0;
        if (qa.size() > 0) ca = qa[0].c;
        if (qb.size() > 0) cb = qb[0].c;
        chk("a_valid", a_out.valid, qa.size() > 0);
        chk("a_data",  a_out.data,  lda);
        chk("a_ctrl",  a_out.ctrl,  ca);
        chk("a_occ",   occ_a,       qa.size());
        chk("b_valid", b_out.valid, qb.size() > 0);
        chk("b_data",  b_out.data,  ldb);
        chk("b_ctrl",  b_out.ctrl,  cb);
        chk("b_occ",   occ_b,       qb.size());
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        ra  = 1'b1;
        lda = '0;
        ldb = '0;
    endtask

    // One clock: drive inputs, check ready lines, advance models, check outputs.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic r, input logic f);
        logic acc_a, acc_b, drn_a, drn_b, rb;
        ent_t e;
        @(negedge CLK);
        iv = v; id = d; ic = c; ordy = r; flush = f;
        #1;
        rb = (qb.size() == 0) || r;
        chk("a_in_ready", a_in.ready, ra);
        chk("b_in_ready", b_in.ready, rb);
        acc_a = v && ra;
        acc_b = v && rb;
        drn_a = (qa.size() > 0) && r;
        drn_b = (qb.size() > 0) && r;
        e.d = d;
        e.c = c;
        @(posedge CLK);
        if (f) begin
            qa.delete();
            qb.delete();
        end else begin
            if (drn_a) void'(qa.pop_front());
            if (acc_a) qa.push_back(e);
            if (drn_b) void'(qb.pop_front());
            if (acc_b) qb.push_back(e);
        end
        if (qa.size() > 0) lda = qa[0].d;
        if (qb.size() > 0) ldb = qb[0].d;
        ra = (qa.size() < 2);
        $display("cyc v=%0d d=%0h r=%0d f=%0d | a occ=%0d d=%0h | b occ=%0d d=%0h",
                 v, d, r, f, qa.size(), lda, qb.size(), ldb);
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        check_outputs();
        chk("rst_a_in_ready", a_in.ready, 1'b1);
        nRST = 1'b1;

        // Streaming 1..8 with the consumer always ready.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), CW'(16'h0100 + i), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-pressure: A then B while stalled, hold, then release.
        step(1'b1, 32'hAAAA_0001, 16'h00A1, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_0002, 16'h00B2, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_0003, 16'h00D3, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while two entries are held and C is offered.
        step(1'b1, 32'h0000_00A0, 16'h1111, 1'b0, 1'b0);
        step(1'b1, 32'h0000_00B0, 16'h2222, 1'b0, 1'b0);
        step(1'b1, 32'h0000_00C0, 16'h3333, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush together with out_ready while one entry is held.
        step(1'b1, 32'h0000_0E00, 16'h4444, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);

        // Bubble after an all-ones control word.
        step(1'b1, 32'h1234_5678, 16'hFFFF, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset with the skid instance holding two entries.
        step(1'b1, 32'h5555_0001, 16'h0F01, 1'b0, 1'b0);
        step(1'b1, 32'h5555_0002, 16'h0F02, 1'b0, 1'b0);
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("arst_a_in_ready", a_in.ready, 1'b1);
        @(negedge CLK);
        nRST = 1'b1;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, CW'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        // Drain anything left and confirm both instances empty.
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("final_a_empty", occ_a, 2'd0);
        chk("final_b_empty", occ_b, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_latch_elastic.md
Name: pipe_latch_elastic

Overview:
Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined datapath. It replaces hand-written per-stage latches with one block carrying an opaque data payload plus a control field, a valid bit, valid/ready handshaking, synchronous flush, and an optional skid slot. The skid slot breaks the combinational ready path between stages. Control bits are forced to zero on bubbles, so killed instructions cannot write registers or memory.

Parameters:
DATA_W, 128, width of payload (instr, pc, rdat, imm, ...); held, never zeroed on bubble
CTRL_W, 16, width of control field (RegWr, MemWr, dREN, dWEN, halt, ...); zeroed whenever slot invalid
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, combinational in_ready

Ports:
CLK  input  1  clock
nRST  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream has a valid instruction
in_ready  output  1  block accepts in_data/in_ctrl this cycle
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bits
out_valid  output  1  out_data/out_ctrl hold a valid instruction
out_ready  input  1  downstream consumes this cycle (= !stall)
out_data  output  DATA_W  registered payload
out_ctrl  output  CTRL_W  registered control; all-zero when out_valid=0
flush  input  1  synchronous kill of all held and incoming entries
occupancy  output  2  number of valid entries held (0..2)

Behaviour:
- Reset (nRST low, async): out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid slot cleared, in_ready=1, state EMPTY.
- Handshake: transfer in when in_valid&in_ready; transfer out when out_valid&out_ready.
- Latency 1 cycle from accepted input to out_valid. Throughput 1 per cycle.
- Stall rule: while out_valid&!out_ready, out_valid/out_data/out_ctrl are bit-stable.
- States (SKID=1): EMPTY, FULL (main valid), SKIDF (main+skid valid). in_ready is a register equal to (next state != SKIDF). No combinational path from out_ready to in_ready.
- EMPTY:
  - in_valid: main<=in, go FULL.
  - else: stay EMPTY.
- FULL:
  - out_ready&in_valid: main<=in, stay FULL.
  - out_ready&!in_valid: go EMPTY; out_ctrl<=0, out_data held.
  - !out_ready&in_valid: skid<=in, go SKIDF.
  - !out_ready&!in_valid: hold.
- SKIDF (in_ready=0):
  - out_ready: main<=skid, go FULL, in_ready=1 next cycle.
  - else: hold.
- SKID=0: single slot. in_ready = !out_valid | out_ready (combinational). Load whenever in_valid&in_ready. States EMPTY/FULL only.
- Flush (priority over all but reset):
  - next state EMPTY; out_valid=0; out_ctrl=0; skid cleared; in_ready=1 next cycle.
  - Input presented in the flush cycle is discarded, even if in_ready=1.
  - out_data holds its last value.
- Flush with out_ready in same cycle: output transfer of current entry completes (consumer sees it), then block empties.
- occupancy: EMPTY=0, FULL=1, SKIDF=2; registered, updated with state.
- No data corruption on back-pressure: entries exit in acceptance order; none dropped except by flush.

Decomposition:
- Shared package pipe_pkg: enum pipe_state_t {EMPTY, FULL, SKIDF}; typedef occ_t (2-bit).
- Stage payload structs (idex_data_t, idex_ctrl_t, ...) also live in pipe_pkg. Users cast these to and from DATA_W/CTRL_W vectors.
- Sub-module pipe_slot: one valid+data+ctrl register with load, clear (zeroes valid and ctrl), and async reset. Instantiated as main slot, plus skid slot under generate when SKID=1.

Test Plan:
- Reset mid-operation: fill to SKIDF, drop nRST asynchronously -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 immediately; no entry survives.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 0x1..0x8 -> out_valid rises 1 cycle after the first accept; out_data 0x1..0x8 on consecutive cycles; occupancy=1 throughout.
- Back-pressure (SKID=1): send A then B with out_ready=0 -> occupancy=2, in_ready=0 the cycle after B, out_data=A stable. Release out_ready -> A then B appear in order; in_ready=1 one cycle after A drains.
- Flush in SKIDF with in_valid=1 (data C) -> next cycle out_valid=0, out_ctrl=0x0000, occupancy=0, C never appears.
- Bubble control: ctrl=0xFFFF accepted, then in_valid=0, out_ready=1 -> after drain out_valid=0, out_ctrl=0x0000, out_data retains the last value.
- SKID=0 instance: out_ready=0 while full -> in_ready=0 combinationally in the same cycle. out_ready=1 with in_valid=1 -> replace in one cycle, no bubble.
